// File: rtl/pico_pkg.sv
// Shared constants and types for the pico-MIPS core.
// Widths here must agree with program_memory.
package pico_pkg;

    localparam int N             = 8;
    localparam int AddrSz        = 6;
    localparam int InstructionSz = 24;

    typedef enum logic {FETCH_RUN, FETCH_HALT} fetch_state_t;

    typedef logic [AddrSz-1:0] pc_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: redirect/stall controls in, PC and instruction register out.
// The master side is the core (decode/execute plus program_memory data).
interface fetch_unit_if;
    import pico_pkg::*;

    logic                     stall;
    logic                     branch_taken;
    logic [N-1:0]             branch_offset;
    logic                     jump;
    logic [AddrSz-1:0]        jump_target;
    logic                     halt_req;
    logic [InstructionSz-1:0] instruction_in;
    logic [AddrSz-1:0]        pc_addr;
    logic [InstructionSz-1:0] instr_out;
    logic [AddrSz-1:0]        instr_pc;
    logic                     instr_valid;
    logic                     halted;

    modport master (
        output stall, branch_taken, branch_offset, jump, jump_target,
               halt_req, instruction_in,
        input  pc_addr, instr_out, instr_pc, instr_valid, halted
    );

    modport slave (
        input  stall, branch_taken, branch_offset, jump, jump_target,
               halt_req, instruction_in,
        output pc_addr, instr_out, instr_pc, instr_valid, halted
    );

endinterface

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: halt > jump > branch > sequential.
// Redirect controls arrive already qualified by the top level.
module pc_next_sel #(
    parameter int N      = 8,
    parameter int AddrSz = 6
) (
    input  logic [AddrSz-1:0] pc,
    input  logic [AddrSz-1:0] instr_pc,
    input  logic              halt,
    input  logic              jump,
    input  logic              branch,
    input  logic [N-1:0]      branch_offset,
    input  logic [AddrSz-1:0] jump_target,
    output logic [AddrSz-1:0] pc_next,
    output logic              flush
);

    localparam int W = (N > AddrSz) ? N : AddrSz;

    logic [W-1:0] offset_ext;
    logic [W-1:0] pc_ext;
    logic [W-1:0] branch_sum;

    // Offset is sign-extended into the wider of the two widths; the sum is then
    // truncated, which gives modulo-2^AddrSz arithmetic for any N.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_ext
            if (gi < N) begin : g_off
                assign offset_ext[gi] = branch_offset[gi];
            end else begin : g_sgn
                assign offset_ext[gi] = branch_offset[N-1];
            end
            if (gi < AddrSz) begin : g_pc
                assign pc_ext[gi] = instr_pc[gi];
            end else begin : g_pad
                assign pc_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign branch_sum = pc_ext + offset_ext;

    always_comb begin
        pc_next = pc + AddrSz'(1);
        flush   = 1'b0;
        if (halt) begin
            pc_next = pc;
            flush   = 1'b1;
        end else if (jump) begin
            pc_next = jump_target;
            flush   = 1'b1;
        end else if (branch) begin
            pc_next = branch_sum[AddrSz-1:0];
            flush   = 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-entry instruction register,
// redirect/flush handling and a sticky HALT state left only by reset.
module fetch_unit #(
    parameter int N             = 8,
    parameter int AddrSz        = 6,
    parameter int InstructionSz = 24
) (
    input  logic         clk,
    input  logic         reset,
    fetch_unit_if.slave  bus
);
    import pico_pkg::*;

    fetch_state_t             state_reg, state_next;
    logic [AddrSz-1:0]        pc_reg;
    logic [InstructionSz-1:0] instr_reg;
    logic [AddrSz-1:0]        ipc_reg;
    logic                     valid_reg;

    logic                     run_en;
    logic                     qual;
    logic                     halt_q, jump_q, branch_q;
    logic [AddrSz-1:0]        pc_next;
    logic                     flush;

    // Redirects belong to the instruction in the register, so they only count
    // when that instruction is valid and the stage actually advances.
    assign run_en   = (state_reg == FETCH_RUN) && !bus.stall;
    assign qual     = run_en && valid_reg;
    assign halt_q   = qual && bus.halt_req;
    assign jump_q   = qual && bus.jump;
    assign branch_q = qual && bus.branch_taken;

    pc_next_sel #(
        .N      (N),
        .AddrSz (AddrSz)
    ) u_pc_next_sel (
        .pc            (pc_reg),
        .instr_pc      (ipc_reg),
        .halt          (halt_q),
        .jump          (jump_q),
        .branch        (branch_q),
        .branch_offset (bus.branch_offset),
        .jump_target   (bus.jump_target),
        .pc_next       (pc_next),
        .flush         (flush)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= FETCH_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH_RUN:  if (halt_q) state_next = FETCH_HALT;
            FETCH_HALT: state_next = FETCH_HALT;
            default:    state_next = FETCH_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_reg    <= '0;
            instr_reg <= '0;
            ipc_reg   <= '0;
            valid_reg <= 1'b0;
        end else if (run_en) begin
            pc_reg <= pc_next;
            if (flush) begin
                valid_reg <= 1'b0;
            end else begin
                instr_reg <= bus.instruction_in;
                ipc_reg   <= pc_reg;
                valid_reg <= 1'b1;
            end
        end
    end

    assign bus.pc_addr     = pc_reg;
    assign bus.instr_out   = instr_reg;
    assign bus.instr_pc    = ipc_reg;
    assign bus.instr_valid = valid_reg;
    assign bus.halted      = (state_reg == FETCH_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory returns 0x100000+addr; a reference model pushes
// the expected outputs for each edge to a queue that is popped after the edge.
module tb_fetch_unit;
    import pico_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    fetch_unit_if bus ();

    fetch_unit #(
        .N             (N),
        .AddrSz        (AddrSz),
        .InstructionSz (InstructionSz)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.instruction_in = 24'h100000 + 24'(bus.pc_addr);

    typedef struct {
        logic [5:0]  pc;
        logic [5:0]  ipc;
        logic [23:0] instr;
        logic        valid;
        logic        halted;
    } exp_t;

    exp_t sb[$];

    logic [5:0]  m_pc, m_ipc;
    logic [23:0] m_instr;
    logic        m_valid, m_halt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_ipc = 0; m_instr = 0; m_valid = 0; m_halt = 0;
    endtask

    // Reference behaviour for one rising edge with the currently driven inputs.
    task automatic model_edge();
        exp_t e;
        int   sum;
        if (!m_halt && !bus.stall) begin
            if (m_valid && bus.halt_req) begin
                m_halt = 1; m_valid = 0;
            end else if (m_valid && bus.jump) begin
                m_pc = bus.jump_target; m_valid = 0;
            end else if (m_valid && bus.branch_taken) begin
                sum = int'(m_ipc) + int'($signed(bus.branch_offset));
                m_pc = 6'(sum & 63); m_valid = 0;
            end else begin
                m_instr = 24'h100000 + 24'(m_pc);
                m_ipc   = m_pc;
                m_valid = 1;
                m_pc    = 6'((int'(m_pc) + 1) & 63);
            end
        end
        e.pc = m_pc; e.ipc = m_ipc; e.instr = m_instr; e.valid = m_valid; e.halted = m_halt;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        model_edge();
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("pc_addr", 32'(bus.pc_addr), 32'(e.pc));
        check("instr_valid", 32'(bus.instr_valid), 32'(e.valid));
        check("halted", 32'(bus.halted), 32'(e.halted));
        if (e.valid) begin
            check("instr_pc", 32'(bus.instr_pc), 32'(e.ipc));
            check("instr_out", 32'(bus.instr_out), 32'(e.instr));
        end
    endtask

    task automatic clear_reqs();
        bus.stall = 0; bus.branch_taken = 0; bus.branch_offset = 0;
        bus.jump = 0; bus.jump_target = 0; bus.halt_req = 0;
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #3;
        reset = 1;
        #1;
        check("rst_pc_addr", 32'(bus.pc_addr), 0);
        check("rst_instr_valid", 32'(bus.instr_valid), 0);
        check("rst_instr_out", 32'(bus.instr_out), 0);
        check("rst_instr_pc", 32'(bus.instr_pc), 0);
        check("rst_halted", 32'(bus.halted), 0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 0;
        @(negedge clk);
        #1;
    endtask

    task automatic run_to(input logic [5:0] target);
        int n = 0;
        while (!(m_valid && m_ipc == target) && n < 200) begin
            step();
            n++;
        end
        check("run_to_reached", 32'(m_valid && m_ipc == target), 1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1;
        clear_reqs();
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        reset = 0;
        @(negedge clk);
        #1;
        repeat (3) step();

        // Reset and streaming
        do_reset();
        step();
        check("stream_first_instr", 32'(bus.instr_out), 32'h100000);
        check("stream_first_valid", 32'(bus.instr_valid), 1);
        step();
        check("stream_second_instr", 32'(bus.instr_out), 32'h100001);

        // Wrap-around
        repeat (65) step();
        run_to(6'd63);
        check("wrap_pc_addr", 32'(bus.pc_addr), 0);
        step();
        check("wrap_instr_pc", 32'(bus.instr_pc), 0);

        // Backward branch
        run_to(6'd10);
        bus.branch_taken = 1; bus.branch_offset = 8'hFD;
        step();
        bus.branch_taken = 0;
        check("br_back_pc", 32'(bus.pc_addr), 7);
        check("br_back_bubble", 32'(bus.instr_valid), 0);
        step();
        check("br_back_ipc", 32'(bus.instr_pc), 7);

        // Wrapping branch
        run_to(6'd2);
        bus.branch_taken = 1; bus.branch_offset = 8'hFD;
        step();
        bus.branch_taken = 0;
        check("br_wrap_pc", 32'(bus.pc_addr), 63);
        step();
        check("br_wrap_ipc", 32'(bus.instr_pc), 63);

        // Forward branch
        run_to(6'd4);
        bus.branch_taken = 1; bus.branch_offset = 8'h05;
        step();
        bus.branch_taken = 0;
        check("br_fwd_pc", 32'(bus.pc_addr), 9);
        step();

        // Jump beats branch, held through a 3-cycle stall
        bus.jump = 1; bus.jump_target = 6'h20; bus.branch_taken = 1; bus.branch_offset = 8'h03;
        bus.stall = 1;
        repeat (3) step();
        check("stall_pc_frozen", 32'(bus.pc_addr), 32'(m_pc));
        bus.stall = 0;
        step();
        bus.jump = 0;
        check("jump_pc", 32'(bus.pc_addr), 32'h20);
        check("jump_bubble", 32'(bus.instr_valid), 0);
        // branch_taken still high during the bubble: must be ignored
        step();
        bus.branch_taken = 0;
        check("unqual_pc", 32'(bus.pc_addr), 32'h21);
        check("unqual_ipc", 32'(bus.instr_pc), 32'h20);
        check("unqual_valid", 32'(bus.instr_valid), 1);

        // Halt
        run_to(6'd5);
        bus.halt_req = 1;
        step();
        bus.halt_req = 0;
        check("halt_halted", 32'(bus.halted), 1);
        check("halt_valid", 32'(bus.instr_valid), 0);
        check("halt_pc", 32'(bus.pc_addr), 6);
        bus.jump = 1; bus.jump_target = 6'h11; bus.branch_taken = 1;
        repeat (3) step();
        clear_reqs();
        check("halt_ignore_pc", 32'(bus.pc_addr), 6);
        do_reset();
        check("post_halt_pc", 32'(bus.pc_addr), 0);
        check("post_halt_halted", 32'(bus.halted), 0);
        step();
        check("post_halt_stream", 32'(bus.instr_out), 32'h100000);

        check("scoreboard_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule
